// File: rtl/kernel_cc_write_back_if.sv
// Memory-write channel (AW/W/B) between the write-back stage and the memory port.
// master drives address/data and b_ready; slave returns ready and the B response.
interface kernel_cc_write_back_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_last;
    logic                  b_valid;
    logic                  b_ready;

    modport master (
        output aw_valid, aw_addr, aw_len, w_valid, w_data, w_last, b_ready,
        input  aw_ready, w_ready, b_valid
    );

    modport slave (
        input  aw_valid, aw_addr, aw_len, w_valid, w_data, w_last, b_ready,
        output aw_ready, w_ready, b_valid
    );
endinterface

// File: rtl/kernel_cc_write_back.sv
// CC write-back: coalesces consecutive-vid label updates into AW/W bursts, pulses done after all B.
// Latency: AW one cycle after a burst closes, first W beat one cycle after the AW handshake.
// Backpressure: holds AW/W stable until ready; stalls issue at MAX_OUTSTANDING. Macro KERNEL_CC_WRITE_BACK_STATS_EN adds counters.
module kernel_cc_write_back #(
    parameter int DATA_WIDTH      = 32,
    parameter int VID_WIDTH       = 32,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_empty_n,
    output logic                            start_read,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic                            upd_empty_n,
    output logic                            upd_read,
    input  logic [VID_WIDTH+DATA_WIDTH:0]   upd_dout,
    kernel_cc_write_back_if.master          mem,
    output logic                            done,
    output logic [31:0]                     stat_bursts,
    output logic [31:0]                     stat_beats
);
    localparam int NW    = $clog2(MAX_BURST) + 1;
    localparam int IW    = NW - 1;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, SEND, DRAIN} state_t;

    state_t                 state;
    logic                   live;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [VID_WIDTH-1:0]   v0;
    logic [NW-1:0]          n;
    logic [NW-1:0]          beat;
    logic                   last_seen;
    logic [3:0]             idle_cnt;
    logic [OW-1:0]          outstanding;
    logic [OW-1:0]          out_next;
    logic [DATA_WIDTH-1:0]  buf_q [MAX_BURST];

    logic [VID_WIDTH-1:0]   head_vid;
    logic [DATA_WIDTH-1:0]  head_label;
    logic                   head_last;
    logic                   consec;
    logic                   n_full;
    logic                   close;
    logic                   aw_fire;
    logic                   w_fire;
    logic                   b_dec;

    assign head_label = upd_dout[DATA_WIDTH-1:0];
    assign head_vid   = upd_dout[DATA_WIDTH +: VID_WIDTH];
    assign head_last  = upd_dout[VID_WIDTH+DATA_WIDTH];

    // Extra top bit makes the all-ones -> 0 wrap compare unequal, so it breaks the run.
    assign consec = ({1'b0, head_vid} == ({1'b0, v0} + (VID_WIDTH+1)'(n)));
    assign n_full = (n == NW'(MAX_BURST));
    assign close  = (n != '0) && (n_full || (upd_empty_n && !consec) || last_seen ||
                                  (!upd_empty_n && idle_cnt == 4'd15));

    assign start_read = live && (state == IDLE) && start_empty_n && !done;
    assign upd_read   = live && (state == COLLECT) && upd_empty_n &&
                        ((n == '0) || (consec && !n_full && !last_seen));

    assign aw_fire     = mem.aw_valid && mem.aw_ready;
    assign w_fire      = mem.w_valid && mem.w_ready;
    assign b_dec       = mem.b_valid && (outstanding != '0);
    assign mem.b_ready = live;

    always_comb begin
        out_next = outstanding;
        if (aw_fire && !b_dec)
            out_next = outstanding + OW'(1);
        else if (!aw_fire && b_dec)
            out_next = outstanding - OW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            live         <= 1'b0;
            base_q       <= '0;
            v0           <= '0;
            n            <= '0;
            beat         <= '0;
            last_seen    <= 1'b0;
            idle_cnt     <= '0;
            outstanding  <= '0;
            done         <= 1'b0;
            mem.aw_valid <= 1'b0;
            mem.aw_addr  <= '0;
            mem.aw_len   <= '0;
            mem.w_valid  <= 1'b0;
            mem.w_data   <= '0;
            mem.w_last   <= 1'b0;
            for (int i = 0; i < MAX_BURST; i++)
                buf_q[i] <= '0;
        end else begin
            live        <= 1'b1;
            done        <= 1'b0;
            outstanding <= out_next;
            case (state)
                IDLE: begin
                    if (start_read) begin
                        base_q    <= base_addr;
                        last_seen <= 1'b0;
                        n         <= '0;
                        idle_cnt  <= '0;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (upd_read) begin
                        buf_q[n[IW-1:0]] <= head_label;
                        n                <= n + NW'(1);
                        if (n == '0)
                            v0 <= head_vid;
                        if (head_last)
                            last_seen <= 1'b1;
                        idle_cnt <= '0;
                    end else if (close) begin
                        idle_cnt <= '0;
                        state    <= ISSUE;
                    end else if (upd_empty_n) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != 4'd15) begin
                        idle_cnt <= idle_cnt + 4'd1;
                    end
                end
                ISSUE: begin
                    if (!mem.aw_valid) begin
                        if (outstanding < OW'(MAX_OUTSTANDING)) begin
                            mem.aw_valid <= 1'b1;
                            mem.aw_addr  <= base_q + (ADDR_WIDTH'(v0) * ADDR_WIDTH'(BYTES));
                            mem.aw_len   <= 8'(n - NW'(1));
                        end
                    end else if (mem.aw_ready) begin
                        // Loading beat 0 here puts the first w_valid one cycle after the handshake.
                        mem.aw_valid <= 1'b0;
                        mem.w_valid  <= 1'b1;
                        mem.w_data   <= buf_q[0];
                        mem.w_last   <= (n == NW'(1));
                        beat         <= NW'(1);
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (w_fire) begin
                        if (mem.w_last) begin
                            mem.w_valid <= 1'b0;
                            mem.w_last  <= 1'b0;
                            n           <= '0;
                            state       <= last_seen ? DRAIN : COLLECT;
                        end else begin
                            mem.w_data <= buf_q[beat[IW-1:0]];
                            mem.w_last <= ((beat + NW'(1)) == n);
                            beat       <= beat + NW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_next == '0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KERNEL_CC_WRITE_BACK_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_bursts <= '0;
            stat_beats  <= '0;
        end else if (start_read) begin
            stat_bursts <= '0;
            stat_beats  <= '0;
        end else begin
            if (aw_fire && stat_bursts != 32'hFFFF_FFFF)
                stat_bursts <= stat_bursts + 32'd1;
            if (w_fire && stat_beats != 32'hFFFF_FFFF)
                stat_beats <= stat_beats + 32'd1;
        end
    end
`else
    assign stat_bursts = '0;
    assign stat_beats  = '0;
`endif
endmodule

// File: tb/tb_kernel_cc_write_back.sv
// Randomized bench for kernel_cc_write_back against a burst-grouping reference model.
module tb_kernel_cc_write_back;
    localparam int DW = 32;
    localparam int VW = 32;
    localparam int AW = 64;

    typedef struct {
        logic [31:0] vid;
        logic [31:0] label;
        logic        last;
        int          delay;
    } upd_t;
    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } aw_exp_t;
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } w_exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_empty_n;
    logic          start_read;
    logic [AW-1:0] base_addr;
    logic          upd_empty_n;
    logic          upd_read;
    logic [VW+DW:0] upd_dout;
    logic          done;
    logic [31:0]   stat_bursts;
    logic [31:0]   stat_beats;

    always #5 clk = ~clk;

    kernel_cc_write_back_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem ();

    kernel_cc_write_back #(
        .DATA_WIDTH(DW), .VID_WIDTH(VW), .ADDR_WIDTH(AW),
        .MAX_BURST(16), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .reset(reset),
        .start_empty_n(start_empty_n), .start_read(start_read), .base_addr(base_addr),
        .upd_empty_n(upd_empty_n), .upd_read(upd_read), .upd_dout(upd_dout),
        .mem(mem), .done(done), .stat_bursts(stat_bursts), .stat_beats(stat_beats)
    );

    int n_cmp = 0;
    int n_err = 0;
    upd_t    tl[$];
    upd_t    pend[$];
    upd_t    uq[$];
    aw_exp_t exp_aw[$];
    w_exp_t  exp_w[$];
    int aw_total, b_total, bursts_done, w_hs_cnt, done_cnt, start_cnt;
    int cyc = 0, last_b_cyc = 0, b_budget = 1 << 30, aw_stall_left = 0, gap_run = 0;
    int exp_bursts, exp_beats;
    bit rdy_always = 0, w_toggle = 0;
    logic        prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, prev_wlast = 0;
    logic [63:0] prev_addr = 0;
    logic [7:0]  prev_len = 0;
    logic [31:0] prev_wdata = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [31:0] vid, input logic [31:0] label, input logic last, input int delay);
        upd_t u;
        u.vid = vid; u.label = label; u.last = last; u.delay = delay;
        tl.push_back(u);
    endtask

    task automatic drive_inputs();
        while (pend.size() > 0 && pend[0].delay == 0) uq.push_back(pend.pop_front());
        if (pend.size() > 0) pend[0].delay--;
        if (!rdy_always && uq.size() > 0 && gap_run < 3 && $urandom_range(0, 4) == 0) begin
            upd_empty_n = 1'b0;
            gap_run++;
        end else begin
            gap_run = 0;
            upd_empty_n = (uq.size() > 0);
        end
        if (uq.size() > 0) upd_dout = {uq[0].last, uq[0].vid, uq[0].label};
        else               upd_dout = {1'b1, $urandom(), $urandom()};
        mem.aw_ready = (aw_stall_left > 0) ? 1'b0 : (rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0));
        mem.w_ready  = w_toggle ? cyc[0] : (rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0));
        mem.b_valid  = (b_budget > 0) && (bursts_done > b_total) &&
                       (rdy_always || $urandom_range(0, 2) != 0);
    endtask

    task automatic cycle();
        logic s_upd, s_start, s_aw, s_w, s_b, s_done;
        aw_exp_t ea;
        w_exp_t  ew;
        @(negedge clk);
        s_upd   = upd_read;
        s_start = start_read;
        s_aw    = mem.aw_valid && mem.aw_ready;
        s_w     = mem.w_valid && mem.w_ready;
        s_b     = mem.b_valid;
        s_done  = done;
        if (s_upd)   chk("pop_valid", upd_empty_n, 1);
        if (s_start) begin chk("start_valid", start_empty_n, 1); start_cnt++; end
        if (prev_awv && !prev_awr) begin
            chk("aw_hold_valid", mem.aw_valid, 1);
            chk("aw_hold_addr", mem.aw_addr, prev_addr);
            chk("aw_hold_len", mem.aw_len, prev_len);
        end
        if (prev_wv && !prev_wr) begin
            chk("w_hold_valid", mem.w_valid, 1);
            chk("w_hold_data", mem.w_data, prev_wdata);
            chk("w_hold_last", mem.w_last, prev_wlast);
        end
        if (s_w) begin
            chk("w_after_aw", aw_total > bursts_done, 1);
            if (exp_w.size() == 0) chk("w_extra_beats", w_hs_cnt + 1, exp_beats);
            else begin
                ew = exp_w.pop_front();
                chk("w_data", mem.w_data, ew.data);
                chk("w_last", mem.w_last, ew.last);
            end
            w_hs_cnt++;
            if (mem.w_last) bursts_done++;
        end
        if (s_aw) begin
            chk("aw_outstanding", aw_total - b_total < 4, 1);
            if (exp_aw.size() == 0) chk("aw_extra_bursts", aw_total + 1, exp_bursts);
            else begin
                ea = exp_aw.pop_front();
                chk("aw_addr", mem.aw_addr, ea.addr);
                chk("aw_len", mem.aw_len, ea.len);
            end
            aw_total++;
        end
        if (s_b) begin
            chk("b_ready", mem.b_ready, 1);
            b_total++;
            last_b_cyc = cyc;
            if (b_budget > 0) b_budget--;
        end
        if (s_done) begin
            done_cnt++;
            chk("done_after_b", cyc - last_b_cyc, 1);
            chk("done_outstanding", aw_total - b_total, 0);
            chk("done_beats_left", exp_w.size(), 0);
        end
        if (mem.aw_valid && aw_stall_left > 0) aw_stall_left--;
        prev_awv = mem.aw_valid; prev_awr = mem.aw_ready; prev_addr = mem.aw_addr; prev_len = mem.aw_len;
        prev_wv = mem.w_valid; prev_wr = mem.w_ready; prev_wdata = mem.w_data; prev_wlast = mem.w_last;
        cyc++;
        @(posedge clk);
        #1;
        if (s_upd && uq.size() > 0) void'(uq.pop_front());
        if (s_start) start_empty_n = 1'b0;
        drive_inputs();
    endtask

    // Reference: a burst is a maximal run of +1 vids, capped at 16, ended by last or a feed stall.
    task automatic start_task(input logic [63:0] base);
        int i, c;
        aw_exp_t ea;
        w_exp_t  ew;
        aw_total = 0; b_total = 0; bursts_done = 0; w_hs_cnt = 0; done_cnt = 0; start_cnt = 0;
        exp_bursts = 0; exp_beats = 0;
        exp_aw.delete(); exp_w.delete();
        i = 0;
        while (i < tl.size()) begin
            c = 1;
            while (i + c < tl.size() && c < 16 && !tl[i+c-1].last && tl[i+c].delay < 40 &&
                   tl[i+c-1].vid != 32'hFFFF_FFFF && tl[i+c].vid == tl[i+c-1].vid + 32'd1)
                c++;
            ea.addr = base + {32'b0, tl[i].vid} * 64'd4;
            ea.len  = 8'(c - 1);
            exp_aw.push_back(ea);
            for (int k = 0; k < c; k++) begin
                ew.data = tl[i+k].label;
                ew.last = (k == c - 1);
                exp_w.push_back(ew);
            end
            exp_bursts++;
            exp_beats += c;
            i += c;
        end
        pend = tl;
        tl.delete();
        base_addr = base;
        start_empty_n = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) cycle();
        chk("done_seen", done_cnt, 1);
        repeat (3) cycle();
        chk("done_once", done_cnt, 1);
        chk("aw_left", exp_aw.size(), 0);
        chk("start_reads", start_cnt, 1);
`ifdef KERNEL_CC_WRITE_BACK_STATS_EN
        chk("stat_bursts", stat_bursts, exp_bursts);
        chk("stat_beats", stat_beats, exp_beats);
`else
        chk("stat_bursts_off", stat_bursts, 0);
        chk("stat_beats_off", stat_beats, 0);
`endif
    endtask

    task automatic random_task();
        int nu;
        logic [31:0] v;
        nu = $urandom_range(1, 40);
        v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 8) : $urandom_range(0, 5000);
        for (int k = 0; k < nu; k++) begin
            add(v, $urandom(), k == nu - 1, 0);
            v = ($urandom_range(0, 5) == 0) ? $urandom() : v + 32'd1;
        end
        start_task({$urandom(), $urandom()});
        wait_done(3000);
    endtask

    initial begin
        reset = 1'b0; start_empty_n = 1'b0; base_addr = '0; upd_empty_n = 1'b0; upd_dout = '0;
        mem.aw_ready = 1'b0; mem.w_ready = 1'b0; mem.b_valid = 1'b0;
        #1;
        chk("reset_outputs", {start_read, upd_read, mem.aw_valid, mem.w_valid, mem.w_last, mem.b_ready, done}, 0);
        chk("reset_stats", {stat_bursts, stat_beats}, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        rdy_always = 1;
        for (int k = 0; k < 4; k++) add(32'd5 + k, 32'hA + k, k == 3, 0);
        start_task(64'h1000);
        wait_done(300);

        rdy_always = 0;
        for (int k = 0; k < 20; k++) add(k, $urandom(), k == 19, 0);
        start_task(64'h1000);
        wait_done(1000);

        add(3, 32'h33, 0, 0); add(4, 32'h44, 0, 0); add(9, 32'h99, 0, 0); add(10, 32'hAA, 1, 0);
        start_task(64'h2000);
        wait_done(1000);

        rdy_always = 1;
        b_budget = 0;
        for (int k = 0; k < 6; k++) add(2 * k, 32'h100 + k, k == 5, 0);
        start_task(64'h3000);
        repeat (60) cycle();
        chk("hold_aw_count", aw_total, 4);
        chk("hold_aw_valid_low", mem.aw_valid, 0);
        b_budget = 1;
        repeat (20) cycle();
        chk("release_aw_count", aw_total, 5);
        chk("release_b_count", b_total, 1);
        chk("release_no_done", done_cnt, 0);
        b_budget = 1 << 30;
        wait_done(500);
        chk("hold_b_total", b_total, 6);

        rdy_always = 0;
        aw_stall_left = 5;
        w_toggle = 1;
        for (int k = 0; k < 12; k++) add(32'd100 + k, $urandom(), k == 11, 0);
        start_task(64'h4000);
        wait_done(1000);
        w_toggle = 0;

        add(0, 32'h10, 0, 0); add(1, 32'h11, 0, 0); add(2, 32'h12, 1, 40);
        start_task(64'h5000);
        wait_done(1000);

        for (int t = 0; t < 8; t++) random_task();

        rdy_always = 1;
        for (int k = 0; k < 4; k++) add(32'd5 + k, 32'hA + k, k == 3, 0);
        start_task(64'h6000);
        for (int k = 0; k < 300 && w_hs_cnt < 2; k++) cycle();
        chk("reset_reached_beat2", w_hs_cnt, 2);
        reset = 1'b0;
        #1;
        chk("midrst_outputs", {start_read, upd_read, mem.aw_valid, mem.w_valid, mem.w_last, mem.b_ready, done}, 0);
        chk("midrst_stats", {stat_bursts, stat_beats}, 0);
        uq.delete(); pend.delete(); exp_aw.delete(); exp_w.delete();
        start_empty_n = 1'b0; upd_empty_n = 1'b0; mem.b_valid = 1'b0;
        prev_awv = 0; prev_wv = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        add(0, 32'h77, 1, 0);
        start_task(64'h7000);
        wait_done(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/kernel_cc_write_back.md
Name: kernel_cc_write_back

Overview:
- Write-back stage of the connected-components kernel; consumes the 1-bit start token produced by the write_back start FIFO.
- Drains a stream of (vertex_id, label) updates from an upstream show-ahead FIFO.
- Coalesces runs of consecutive vertex IDs into bursts and issues them on a simple AW/W/B memory-write channel.
- Pulses done once every burst of the task has been acknowledged.

Parameters:
- DATA_WIDTH, 32, label width and W data width.
- VID_WIDTH, 32, vertex ID width.
- ADDR_WIDTH, 64, byte address width.
- MAX_BURST, 16, max beats per burst; power of two, 2..256.
- MAX_OUTSTANDING, 4, max bursts issued without a B response.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start_empty_n  in  1  start FIFO has a token.
- start_read  out  1  pop start token.
- base_addr  in  ADDR_WIDTH  label-array base; sampled when the token is popped.
- upd_empty_n  in  1  update FIFO non-empty; upd_dout is valid whenever this is 1.
- upd_read  out  1  pop update.
- upd_dout  in  1+VID_WIDTH+DATA_WIDTH  {last, vid, label}.
- aw_valid  out  1  address request valid.
- aw_ready  in  1  address request accepted.
- aw_addr  out  ADDR_WIDTH  burst start byte address.
- aw_len  out  8  beats minus 1.
- w_valid  out  1  write beat valid.
- w_ready  in  1  write beat accepted.
- w_data  out  DATA_WIDTH  label.
- w_last  out  1  final beat of burst.
- b_valid  in  1  write response.
- b_ready  out  1  always 1 outside reset.
- done  out  1  one-cycle task-complete pulse.
- stat_bursts  out  32  burst counter (optional feature).
- stat_beats  out  32  beat counter (optional feature).

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0 (start_read, upd_read, aw_valid, w_valid, w_last, b_ready, done, stats). Buffer and counters cleared. Reset mid-burst abandons the burst; no completion is owed.
- IDLE:
  - If start_empty_n: assert start_read for 1 cycle, latch base_addr, clear last_seen, go to COLLECT.
- COLLECT: burst buffer is MAX_BURST x DATA_WIDTH, with beat count n and start vid v0.
  - Pop (upd_read=1) only when upd_empty_n and one of: n==0, or (vid==v0+n and n<MAX_BURST and !last_seen).
  - On pop: store label; set v0=vid if n==0; set last_seen if last.
  - Go to ISSUE when n>0 and any of: n==MAX_BURST; head vid != v0+n; last_seen; upd_empty_n is 0 for 16 consecutive cycles (flush timeout).
  - VID arithmetic is modulo 2^VID_WIDTH. Wrap from all-ones to 0 is not consecutive and closes the burst.
- ISSUE:
  - Wait until outstanding < MAX_OUTSTANDING, then drive aw_valid with aw_addr = latched base + v0*(DATA_WIDTH/8), truncated to ADDR_WIDTH, and aw_len = n-1.
  - Hold aw_valid and all AW fields stable until aw_ready. On the handshake: outstanding+1, go to SEND.
- SEND:
  - Beats i = 0..n-1: w_valid=1, w_data=buf[i], w_last=(i==n-1); hold stable until w_ready.
  - After the last beat: n=0; go to DRAIN if last_seen, else COLLECT.
- DRAIN: when outstanding==0, assert done for 1 cycle, go to IDLE.
- Outstanding counter:
  - b_valid decrements it, in any state.
  - Same-cycle AW handshake and b_valid leave it unchanged.
  - b_valid with outstanding==0 is ignored.
- Ordering: the AW handshake always precedes the burst's first W beat; there is 1 cycle minimum from the AW handshake to the first w_valid.
- A task whose first update has last=1 yields exactly one 1-beat burst.
- A token arriving during a task is not read until after done.

Optional Feature:
- Macro KERNEL_CC_WRITE_BACK_STATS_EN.
- Defined:
  - stat_bursts increments on each AW handshake; stat_beats increments on each W handshake.
  - Both saturate at 2^32-1; both clear at reset and on each start-token pop.
- Undefined: stat_bursts and stat_beats tied to 0; no counter logic.

Test Plan:
- base=0x1000; updates vid 5..8 (labels 0xA..0xD, last on vid 8); ready always 1 -> one AW: addr 0x1014, len 3; W data 0xA..0xD, w_last on the 4th beat; done 1 cycle after the single b_valid.
- 20 consecutive vids 0..19, last on 19 -> AW len 15 @0x1000, then AW len 3 @0x1040; 20 W beats; with the macro defined, stat_bursts=2 and stat_beats=20.
- vids 3,4,9,10, last on 10 -> two bursts: len 1 @base+12, len 1 @base+36.
- b_valid withheld, 6 single-beat noncontiguous updates -> exactly 4 AW handshakes, then aw_valid held; releasing 1 response lets the 5th AW issue; done only after 6 responses.
- aw_ready held 0 for 5 cycles, w_ready toggled -> AW and W fields stable while valid and not ready; no beat lost or duplicated.
- reset driven low during SEND beat 2 -> all outputs 0 immediately; after release, a new token + vid 0, last -> a normal 1-beat burst and done.
